fmul_dispatch: RTL and testbench

Single-outstanding issue/return controller that sits directly upstream of the FPU multiplier and feeds it. It accepts a multiply request from the core pipeline over valid/ready and latches the operands. It then drives the multiplier's order/accepted/done handshake, holding operands stable for the whole operation, and returns the tagged result over valid/ready. A watchdog converts a missing `done` into an error response, so the core never hangs.

---
 rtl/fmul_dispatch_if.sv | 57 +++++
 rtl/fmul_dispatch.sv | 144 ++++++++++++++
 tb/tb_fmul_dispatch.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : fmul_dispatch_if
// Description : Bundle of the core request, result return and multiplier
//               order/accepted/done signals around fmul_dispatch.
//               master = core + multiplier side, slave = fmul_dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
interface fmul_dispatch_if #(
  parameter int TAG_W = 5
);
  // core request
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;

  // multiplier handshake
  logic             mul_order;
  logic             mul_accepted;
  logic             mul_done;
  logic [31:0]      mul_rs1;
  logic [31:0]      mul_rs2;
  logic [31:0]      mul_rd;

  // result return
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  // status
  logic             busy;
  logic             err;

  modport master (
    output req_valid, req_rs1, req_rs2, req_tag,
    input  req_ready,
    input  mul_order, mul_rs1, mul_rs2,
    output mul_accepted, mul_done, mul_rd,
    input  res_valid, res_data, res_tag,
    output res_ready,
    input  busy, err
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_tag,
    output req_ready,
    output mul_order, mul_rs1, mul_rs2,
    input  mul_accepted, mul_done, mul_rd,
    output res_valid, res_data, res_tag,
    input  res_ready,
    output busy, err
  );
endinterface
`default_nettype wire

// File: rtl/fmul_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : fmul_dispatch
// Description : Single-outstanding issue/return controller in front of the
//               FPU multiplier. Latches a request, orders the multiplier,
//               waits for done under a watchdog, returns the tagged result.
//               Optional macro FMUL_DISPATCH_ZERO_SHORTCUT_EN: a request with
//               a signed-zero operand bypasses the multiplier and answers
//               with a signed zero in the cycle after the handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_dispatch #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fmul_dispatch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [31:0] c_qnan    = 32'h7FC0_0000;
  localparam logic [7:0]  c_timeout = 8'(TIMEOUT);

  // Watchdog counter is 8 bits wide, so the limit must fit and leave room
  // for a realistic multiplier latency.
  if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_timeout_range
    $error("fmul_dispatch: TIMEOUT must be within 4..255");
  end

  state_t           r_state;
  logic             r_live;       // low while in reset, keeps req_ready at 0
  logic [7:0]       r_wd_cnt;
  logic             r_mul_order;
  logic [31:0]      r_mul_rs1;
  logic [31:0]      r_mul_rs2;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic [TAG_W-1:0] r_res_tag;
  logic             r_err;

  logic             w_req_ready;
  logic             w_req_fire;
  logic             w_zero_op;

  // Accept a new request when idle, or when the current result leaves this cycle.
  assign w_req_ready = (r_state == S_IDLE && r_live) ||
                       (r_state == S_RESP && bus.res_ready);
  assign w_req_fire  = bus.req_valid && w_req_ready;

`ifdef FMUL_DISPATCH_ZERO_SHORTCUT_EN
  // Exponent and mantissa all zero on either operand: product is a signed zero.
  assign w_zero_op = (bus.req_rs1[30:0] == 31'd0) || (bus.req_rs2[30:0] == 31'd0);
`else
  assign w_zero_op = 1'b0;
`endif

  // Controller FSM with registered handshake outputs and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_wd_cnt    <= 8'd0;
      r_mul_order <= 1'b0;
      r_mul_rs1   <= 32'd0;
      r_mul_rs2   <= 32'd0;
      r_res_valid <= 1'b0;
      r_res_data  <= 32'd0;
      r_res_tag   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_live <= 1'b1;

      case (r_state)
        S_ISSUE: begin
          if (bus.mul_accepted) begin
            r_mul_order <= 1'b0;
            r_wd_cnt    <= 8'd0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // done takes priority over a watchdog expiry in the same cycle
          if (bus.mul_done) begin
            r_res_data  <= bus.mul_rd;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_wd_cnt == c_timeout) begin
            r_res_data  <= c_qnan;
            r_err       <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          // S_IDLE: stray accepted/done are ignored
        end
      endcase

      // A request handshake overrides the RESP exit for back-to-back issue.
      if (w_req_fire) begin
        r_mul_rs1 <= bus.req_rs1;
        r_mul_rs2 <= bus.req_rs2;
        r_res_tag <= bus.req_tag;
        if (w_zero_op) begin
          r_res_data  <= {bus.req_rs1[31] ^ bus.req_rs2[31], 31'd0};
          r_res_valid <= 1'b1;
          r_mul_order <= 1'b0;
          r_state     <= S_RESP;
        end else begin
          r_res_valid <= 1'b0;
          r_mul_order <= 1'b1;
          r_state     <= S_ISSUE;
        end
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.mul_order = r_mul_order;
  assign bus.mul_rs1   = r_mul_rs1;
  assign bus.mul_rs2   = r_mul_rs2;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_tag   = r_res_tag;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fmul_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_dispatch
// Description : Directed self-checking bench for fmul_dispatch with a
//               3-cycle multiplier model (accept delay and done mute knobs).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fmul_dispatch;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmul_dispatch_if #(.TAG_W(TAG_W)) bus ();

  fmul_dispatch #(.TAG_W(TAG_W), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // multiplier model: accept after acc_delay order cycles, done 3 cycles later
  logic [31:0] prod_q[$];
  logic [31:0] rd_r      = 32'd0;
  int          k         = 0;
  int          ord_wait  = 0;
  int          acc_delay = 0;
  bit          done_en   = 1'b1;

  assign bus.mul_accepted = bus.mul_order && (ord_wait >= acc_delay);
  assign bus.mul_done     = done_en && (k == 1);
  assign bus.mul_rd       = rd_r;

  always @(posedge clk) begin
    if (bus.mul_order && !bus.mul_accepted) ord_wait <= ord_wait + 1;
    else                                    ord_wait <= 0;
    if (k > 0) k <= k - 1;
    if (bus.mul_order && bus.mul_accepted) begin
      k <= 3;
      if (prod_q.size() > 0) rd_r <= prod_q.pop_front();
      else                   rd_r <= 32'd0;
    end
  end

  // cycle counter, order-high counter, result monitor
  int          cyc    = 0;
  int          ord_hi = 0;
  logic [31:0] q_data[$];
  logic [31:0] q_tag[$];
  int          q_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mul_order) ord_hi <= ord_hi + 1;
    if (bus.res_valid && bus.res_ready) begin
      q_data.push_back(bus.res_data);
      q_tag.push_back(32'(bus.res_tag));
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // present one request, return the handshake cycle number
  task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, output int t_hs);
    int n;
    bus.req_valid = 1'b1;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_tag   = t;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    t_hs = cyc - 1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_res(input int limit, output int seen_cyc);
    int n;
    n = 0;
    while (!bus.res_valid && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("res_valid_wait", {31'd0, bus.res_valid}, 32'd1);
    seen_cyc = cyc;
  endtask

  logic [31:0] ops [4];
  logic [31:0] sq  [4];

  initial begin
    int t_hs, t_res, o0, nb, seen;
    bit bad;

    ops = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    sq  = '{32'h3F80_0000, 32'h4080_0000, 32'h4110_0000, 32'h4180_0000};

    bus.req_valid = 1'b0;
    bus.req_rs1   = 32'd0;
    bus.req_rs2   = 32'd0;
    bus.req_tag   = '0;
    bus.res_ready = 1'b1;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_mul_order", {31'd0, bus.mul_order}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_err",       {31'd0, bus.err},       32'd0);
    chk("rst_res_data",  bus.res_data,           32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // ---- basic 2.0 x 3.0, tag 7
    prod_q.push_back(32'h40C0_0000);
    o0 = ord_hi;
    do_req(32'h4000_0000, 32'h4040_0000, 5'd7, t_hs);
    chk("basic_issue_order", {31'd0, bus.mul_order}, 32'd1);
    chk("basic_mul_rs1",     bus.mul_rs1,            32'h4000_0000);
    chk("basic_mul_rs2",     bus.mul_rs2,            32'h4040_0000);
    wait_res(20, t_res);
    chk("basic_latency",  32'(t_res - t_hs),  32'd5);
    chk("basic_res_data", bus.res_data,       32'h40C0_0000);
    chk("basic_res_tag",  32'(bus.res_tag),   32'd7);
    chk("basic_order_cycles", 32'(ord_hi - o0), 32'd1);
    @(posedge clk); #1;
    chk("basic_back_idle", {31'd0, bus.busy}, 32'd0);

    // ---- backpressure: res_ready low 10 cycles
    bus.res_ready = 1'b0;
    prod_q.push_back(32'h40C0_0000);
    do_req(32'h4000_0000, 32'h4040_0000, 5'd9, t_hs);
    wait_res(20, t_res);
    bad = 1'b0;
    repeat (10) begin
      if (bus.res_data !== 32'h40C0_0000 || bus.res_tag !== 5'd9 ||
          bus.req_ready !== 1'b0 || bus.res_valid !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_stable", {31'd0, bad}, 32'd0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle",  {31'd0, bus.busy},      32'd0);
    chk("bp_release_valid", {31'd0, bus.res_valid}, 32'd0);

    // ---- back-to-back: four squares with req_valid held high
    q_data.delete(); q_tag.delete(); q_cyc.delete();
    for (int i = 0; i < 4; i++) prod_q.push_back(sq[i]);
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_rs1   = ops[i];
      bus.req_rs2   = ops[i];
      bus.req_tag   = 5'(i + 1);
      nb = 0;
      while (!bus.req_ready && nb < 20) begin
        @(posedge clk); #1;
        nb++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_count", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      chk("b2b_data", q_data[i], sq[i]);
      chk("b2b_tag",  q_tag[i],  32'(i + 1));
      if (i > 0) chk("b2b_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 32'd5);
    end

    // ---- zero operand: -0.0 x 1.0
    o0 = ord_hi;
`ifndef FMUL_DISPATCH_ZERO_SHORTCUT_EN
    prod_q.push_back(32'h8000_0000);
`endif
    do_req(32'h8000_0000, 32'h3F80_0000, 5'd11, t_hs);
    if (!bus.res_valid) wait_res(20, t_res);
    else t_res = cyc;
    chk("zero_res_data", bus.res_data,     32'h8000_0000);
    chk("zero_res_tag",  32'(bus.res_tag), 32'd11);
`ifdef FMUL_DISPATCH_ZERO_SHORTCUT_EN
    chk("zero_latency",      32'(t_res - t_hs), 32'd1);
    chk("zero_order_cycles", 32'(ord_hi - o0),  32'd0);
`else
    chk("zero_latency",      32'(t_res - t_hs), 32'd5);
    chk("zero_order_cycles", 32'(ord_hi - o0),  32'd1);
`endif
    @(posedge clk); #1;

    // ---- accept delayed two cycles adds two cycles of latency
    acc_delay = 2;
    prod_q.push_back(32'h40C0_0000);
    o0 = ord_hi;
    do_req(32'h4000_0000, 32'h4040_0000, 5'd2, t_hs);
    wait_res(20, t_res);
    chk("accdly_latency",      32'(t_res - t_hs), 32'd7);
    chk("accdly_order_cycles", 32'(ord_hi - o0),  32'd3);
    chk("accdly_res_data",     bus.res_data,      32'h40C0_0000);
    acc_delay = 0;
    @(posedge clk); #1;

    // ---- watchdog: done never arrives
    done_en = 1'b0;
    do_req(32'h4000_0000, 32'h4040_0000, 5'd3, t_hs);
    wait_res(40, t_res);
    chk("wd_latency",  32'(t_res - t_hs),  32'd18);
    chk("wd_res_data", bus.res_data,       32'h7FC0_0000);
    chk("wd_res_tag",  32'(bus.res_tag),   32'd3);
    chk("wd_err",      {31'd0, bus.err},   32'd1);
    @(posedge clk); #1;
    done_en = 1'b1;
    prod_q.push_back(32'h3F80_0000);
    do_req(32'h3F80_0000, 32'h3F80_0000, 5'd4, t_hs);
    wait_res(20, t_res);
    chk("wd_next_data",      bus.res_data,     32'h3F80_0000);
    chk("wd_err_sticky",     {31'd0, bus.err}, 32'd1);
    @(posedge clk); #1;

    // ---- reset two cycles after accept, done then arrives while idle
    prod_q.push_back(32'h40C0_0000);
    do_req(32'h4000_0000, 32'h4040_0000, 5'd5, t_hs);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_busy",      {31'd0, bus.busy},      32'd0);
    chk("mrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("mrst_mul_order", {31'd0, bus.mul_order}, 32'd0);
    chk("mrst_err",       {31'd0, bus.err},       32'd0);
    chk("mrst_mul_rs1",   bus.mul_rs1,            32'd0);
    chk("mrst_res_tag",   32'(bus.res_tag),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      if (bus.res_valid) seen = 1;
      @(posedge clk); #1;
    end
    chk("mrst_no_result", 32'(seen),              32'd0);
    chk("mrst_req_ready_after", {31'd0, bus.req_ready}, 32'd1);
    chk("mrst_idle_after",      {31'd0, bus.busy},      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
